// File: rtl/psw_conditioner.sv
// Push-switch input conditioner: sync, debounce, press pulses, sticky flags, CPU read-and-clear, IRQ.
// Define PSW_AUTOREPEAT_EN to add per-line auto-repeat press events while a switch is held.
module psw_conditioner #(
    parameter int unsigned N_SW      = 20,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned DB_TICKS  = 4,
    parameter int unsigned REP_DELAY = 50,
    parameter int unsigned REP_RATE  = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_SW-1:0] PSW_IN,
    output logic [N_SW-1:0] PSW_LEVEL,
    output logic [N_SW-1:0] PSW_PRESS,
    output logic [N_SW-1:0] EVT_PEND,
    input  logic            RD_STB,
    output logic [N_SW-1:0] RD_DATA,
    output logic            RD_VALID,
    output logic            IRQ
);

    localparam int unsigned DIV_W = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
    localparam int unsigned DB_W  = ($clog2(DB_TICKS) < 1) ? 1 : $clog2(DB_TICKS);

    logic [N_SW-1:0]  sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [N_SW-1:0]  sw;
    logic [N_SW-1:0]  level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q [N_SW];
    logic [DB_W-1:0]  db_cnt_d [N_SW];
    logic [N_SW-1:0]  rep_fire;
    logic [N_SW-1:0]  press_q, press_d;
    logic [N_SW-1:0]  pend_q, pend_d;
    logic [N_SW-1:0]  rd_data_q, rd_data_d;
    logic             rd_valid_q;
    logic             irq_q;

    assign sw   = ~sync2_q;
    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Any tick on which the synchronised line agrees with the level restarts the count.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (tick) begin
            for (int unsigned i = 0; i < N_SW; i++) begin
                if (sw[i] != level_q[i]) begin
                    if (db_cnt_q[i] == DB_W'(DB_TICKS - 1)) begin
                        level_d[i]  = sw[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

`ifdef PSW_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned REP_W   = ($clog2(REP_MAX) < 1) ? 1 : $clog2(REP_MAX);

    logic [REP_W-1:0] rep_cnt_q [N_SW];
    logic [REP_W-1:0] rep_cnt_d [N_SW];
    logic [N_SW-1:0]  rep_arm_q, rep_arm_d;

    // rep_arm selects the period: initial delay until the first repeat, then the repeat rate.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_arm_d = rep_arm_q;
        rep_fire  = '0;
        for (int unsigned i = 0; i < N_SW; i++) begin
            if (!level_q[i] || !level_d[i]) begin
                rep_cnt_d[i] = '0;
                rep_arm_d[i] = 1'b0;
            end else if (tick) begin
                if (rep_cnt_q[i] == (rep_arm_q[i] ? REP_W'(REP_RATE - 1) : REP_W'(REP_DELAY - 1))) begin
                    rep_fire[i]  = 1'b1;
                    rep_cnt_d[i] = '0;
                    rep_arm_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rep_arm_q <= '0;
            for (int unsigned i = 0; i < N_SW; i++) rep_cnt_q[i] <= '0;
        end else begin
            rep_arm_q <= rep_arm_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign rep_fire = '0;
`endif

    // A press arriving with the strobe survives the clear and stays out of the snapshot.
    always_comb begin
        press_d   = (level_d & ~level_q) | rep_fire;
        pend_d    = (RD_STB ? '0 : pend_q) | press_q;
        rd_data_d = RD_STB ? pend_q : rd_data_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            div_q      <= '0;
            level_q    <= '0;
            press_q    <= '0;
            pend_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            for (int unsigned i = 0; i < N_SW; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q    <= PSW_IN;
            sync2_q    <= sync1_q;
            div_q      <= div_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= RD_STB;
            irq_q      <= |pend_q;
        end
    end

    assign PSW_LEVEL = level_q;
    assign PSW_PRESS = press_q;
    assign EVT_PEND  = pend_q;
    assign RD_DATA   = rd_data_q;
    assign RD_VALID  = rd_valid_q;
    assign IRQ       = irq_q;

endmodule
